// File: rtl/demuxer5_hold_pkg.sv
// Shared constants and types for the 32-way demultiplexer with hold registers.
// The state encodings match the 32:1 selector so both blocks decode states the same way.
package demuxer5_hold_pkg;

  localparam int NCH   = 32;
  localparam int SEL_W = 5;
  localparam int CNT_W = 8;

  localparam logic [0:0] ST_TRACK  = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Blanking reload value; anything above 255 is outside the legal range and is truncated.
  function automatic cnt_t blank_load(input int unsigned blank);
    return cnt_t'(blank);
  endfunction

endpackage

// File: rtl/demuxer5_hold_if.sv
// Sample-stream and channel-output bundle of demuxer5_hold.
// The master side drives the sample stream; the slave side is the demultiplexer.
interface demuxer5_hold_if #(
  parameter int RES = 14
);
  import demuxer5_hold_pkg::*;

  sel_t                 sel;
  logic [RES-1:0]       in;
  logic                 in_valid;
  logic                 hold_i;
  logic                 clr_i;
  logic [NCH*RES-1:0]   out_flat;
  logic [NCH-1:0]       updated_o;
  logic                 wr_o;
  sel_t                 ch_o;
  logic                 settling_o;

  modport master (
    output sel, in, in_valid, hold_i, clr_i,
    input  out_flat, updated_o, wr_o, ch_o, settling_o
  );

  modport slave (
    input  sel, in, in_valid, hold_i, clr_i,
    output out_flat, updated_o, wr_o, ch_o, settling_o
  );

endinterface

// File: rtl/demuxer5_hold_ch_reg.sv
// One channel hold register: write-enabled data register plus sticky "written" flag.
// Synchronous clear wins over a simultaneous write.
module demux_ch_reg #(
  parameter int RES = 14
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           i_we,
  input  logic           i_clr,
  input  logic [RES-1:0] i_d,
  output logic [RES-1:0] o_q,
  output logic           o_upd
);

  logic [RES-1:0] r_q;
  logic           r_upd;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_q   <= '0;
      r_upd <= 1'b0;
    end else if (i_clr) begin
      r_q   <= '0;
      r_upd <= 1'b0;
    end else if (i_we) begin
      r_q   <= i_d;
      r_upd <= 1'b1;
    end
  end

  assign o_q   = r_q;
  assign o_upd = r_upd;

endmodule

// File: rtl/demuxer5_hold.sv
// 32-way registered demultiplexer: routes a sample stream into per-channel hold registers,
// blanking writes for BLANK cycles after each select change while the source settles.
module demuxer5_hold
  import demuxer5_hold_pkg::*;
#(
  parameter int RES   = 14,
  parameter int BLANK = 4
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  demuxer5_hold_if.slave bus
);

  localparam cnt_t       BLANK_LD  = blank_load(BLANK);
  localparam logic [0:0] ST_ON_CHG = (BLANK > 0) ? ST_SETTLE : ST_TRACK;

  logic [0:0]         r_state;
  sel_t               r_sel;
  cnt_t               r_cnt;
  logic               r_wr;

  logic [0:0]         w_state_nxt;
  sel_t               w_sel_nxt;
  cnt_t               w_cnt_nxt;
  logic               w_sel_chg;
  logic               w_wr;
  logic [NCH-1:0]     w_we;
  logic [RES-1:0]     w_q   [NCH];
  logic               w_upd [NCH];
  logic [NCH*RES-1:0] w_flat;
  logic [NCH-1:0]     w_upd_v;

  assign w_sel_chg = (bus.sel != r_sel);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_TRACK: begin
        if (w_sel_chg) begin
          w_sel_nxt   = bus.sel;
          w_cnt_nxt   = BLANK_LD;
          w_state_nxt = ST_ON_CHG;
        end else begin
          w_state_nxt = ST_TRACK;
        end
      end
      ST_SETTLE: begin
        if (w_sel_chg) begin
          w_sel_nxt   = bus.sel;
          w_cnt_nxt   = BLANK_LD;
          w_state_nxt = ST_SETTLE;
        end else if (r_cnt <= cnt_t'(1)) begin
          // A zero count cannot occur here normally; leaving on it avoids a 255-cycle stall.
          w_cnt_nxt   = '0;
          w_state_nxt = ST_TRACK;
        end else begin
          w_cnt_nxt   = r_cnt - cnt_t'(1);
          w_state_nxt = ST_SETTLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_TRACK;
      end
    endcase
  end

  assign w_wr = (r_state == ST_TRACK) & bus.in_valid & ~bus.hold_i & ~bus.clr_i & ~w_sel_chg;

  always_comb begin
    w_we = '0;
    for (int k = 0; k < NCH; k++) begin
      w_we[k] = w_wr & (r_sel == sel_t'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_TRACK;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr    <= w_wr;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    demux_ch_reg #(
      .RES (RES)
    ) u_ch (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .i_we   (w_we[k]),
      .i_clr  (bus.clr_i),
      .i_d    (bus.in),
      .o_q    (w_q[k]),
      .o_upd  (w_upd[k])
    );
  end

  always_comb begin
    w_flat  = '0;
    w_upd_v = '0;
    for (int k = 0; k < NCH; k++) begin
      w_flat[k*RES +: RES] = w_q[k];
      w_upd_v[k]           = w_upd[k];
    end
  end

  assign bus.out_flat   = w_flat;
  assign bus.updated_o  = w_upd_v;
  assign bus.wr_o       = r_wr;
  assign bus.ch_o       = r_sel;
  assign bus.settling_o = r_state[0];

endmodule

// File: tb/tb_demuxer5_hold.sv
// Scoreboard bench for demuxer5_hold: one instance with BLANK=4 and one with BLANK=0.
module tb_demuxer5_hold;

  localparam int RES = 14;
  localparam int W   = 32 * RES;

  typedef struct packed {
    logic [4:0]     ch;
    logic [RES-1:0] data;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;
  int   n_wr4;
  exp_t q4[$];
  exp_t q0[$];
  logic [W-1:0] exp_flat;

  demuxer5_hold_if #(.RES(RES)) if4 ();
  demuxer5_hold_if #(.RES(RES)) if0 ();

  demuxer5_hold #(.RES(RES), .BLANK(4)) u_dut4 (.clk_i(clk), .rstn_i(rstn), .bus(if4));
  demuxer5_hold #(.RES(RES), .BLANK(0)) u_dut0 (.clk_i(clk), .rstn_i(rstn), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int d, input logic [4:0] s, input logic [RES-1:0] din,
                     input logic v, input logic h, input logic c, input logic e);
    @(negedge clk);
    if (d == 4) begin
      if4.sel = s; if4.in = din; if4.in_valid = v; if4.hold_i = h; if4.clr_i = c;
      if (e) q4.push_back('{ch: s, data: din});
    end else begin
      if0.sel = s; if0.in = din; if0.in_valid = v; if0.hold_i = h; if0.clr_i = c;
      if (e) q0.push_back('{ch: s, data: din});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    cyc(4, if4.sel, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(0, if0.sel, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("q4_drained", W'(q4.size()), W'(0));
    check_eq("q0_drained", W'(q0.size()), W'(0));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_flat"}, if4.out_flat, W'(0));
    check_eq({tag, "_upd"}, W'(if4.updated_o), W'(0));
    check_eq({tag, "_wr"}, W'(if4.wr_o), W'(0));
    check_eq({tag, "_ch"}, W'(if4.ch_o), W'(0));
    check_eq({tag, "_settle"}, W'(if4.settling_o), W'(0));
  endtask

  // Scoreboard for the BLANK=4 instance: every wr_o pulse must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && if4.wr_o) begin
      n_wr4++;
      check_eq("wr4_pending", W'(q4.size() > 0), W'(1));
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check_eq("wr4_ch", W'(if4.ch_o), W'(e.ch));
        check_eq("wr4_data", W'(if4.out_flat[e.ch*RES +: RES]), W'(e.data));
      end
    end
  end

  // Scoreboard for the BLANK=0 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && if0.wr_o) begin
      check_eq("wr0_pending", W'(q0.size() > 0), W'(1));
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_eq("wr0_ch", W'(if0.ch_o), W'(e.ch));
        check_eq("wr0_data", W'(if0.out_flat[e.ch*RES +: RES]), W'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_hi;
    int wr_before;
    n_checks = 0; n_fail = 0; n_wr4 = 0;
    rstn = 1'b0;
    if4.sel = '0; if4.in = '0; if4.in_valid = 1'b0; if4.hold_i = 1'b0; if4.clr_i = 1'b0;
    if0.sel = '0; if0.in = '0; if0.in_valid = 1'b0; if0.hold_i = 1'b0; if0.clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Two writes to channel 0 with no select change.
    wr_before = n_wr4;
    cyc(4, 5'd0, 14'h0123, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("s1_first", W'(if4.out_flat[RES-1:0]), W'(14'h0123));
    cyc(4, 5'd0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4, 5'd0, 14'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(4, 5'd0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4, 5'd0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s1_wr_count", W'(n_wr4 - wr_before), W'(2));
    check_eq("s1_upd", W'(if4.updated_o), W'(32'h1));
    check_eq("s1_flat", if4.out_flat, W'(14'h1ABC));
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    check_zero("s1_reset");

    // Select 0 -> 7 with continuous valid: change cycle plus 4 blanked cycles drop samples.
    cnt_hi = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(4, 5'd7, RES'(14'h100 + i), 1'b1, 1'b0, 1'b0, i >= 5);
      check_eq("s2_settle", W'(if4.settling_o), W'(i < 4));
      if (if4.settling_o) cnt_hi++;
    end
    cyc(4, 5'd7, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s2_settle_len", W'(cnt_hi), W'(4));
    check_eq("s2_ch7", W'(if4.out_flat[7*RES +: RES]), W'(14'h109));
    check_eq("s2_upd", W'(if4.updated_o), W'(32'h80));
    check_eq("s2_ch_o", W'(if4.ch_o), W'(7));
    flush();

    // BLANK=0: only the change-cycle sample is dropped, settling never rises.
    cyc(0, 5'd3, 14'h050, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("s3_settle_a", W'(if0.settling_o), W'(0));
    cyc(0, 5'd3, 14'h051, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 5'd4, RES'(14'h200 + i), 1'b1, 1'b0, 1'b0, i >= 1);
      check_eq("s3_settle", W'(if0.settling_o), W'(0));
    end
    cyc(0, 5'd4, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s3_ch4", W'(if0.out_flat[4*RES +: RES]), W'(14'h205));
    check_eq("s3_ch3", W'(if0.out_flat[3*RES +: RES]), W'(14'h051));
    check_eq("s3_upd", W'(if0.updated_o), W'(32'h18));
    flush();

    // Re-select during SETTLE: 1 -> 2, then 2 -> 5 after two cycles.
    for (int i = 0; i < 6; i++) cyc(4, 5'd1, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4, 5'd2, 14'h300, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4, 5'd2, 14'h301, 1'b1, 1'b0, 1'b0, 1'b0);
    cnt_hi = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(4, 5'd5, RES'(14'h400 + i), 1'b1, 1'b0, 1'b0, i >= 5);
      check_eq("s4_settle", W'(if4.settling_o), W'(i < 4));
      if (if4.settling_o) cnt_hi++;
    end
    cyc(4, 5'd5, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s4_settle_len", W'(cnt_hi), W'(4));
    check_eq("s4_ch2", W'(if4.out_flat[2*RES +: RES]), W'(0));
    check_eq("s4_upd2", W'(if4.updated_o[2]), W'(0));
    check_eq("s4_ch5", W'(if4.out_flat[5*RES +: RES]), W'(14'h407));
    flush();

    // Fill every channel with its own index.
    exp_flat = '0;
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 5; j++) cyc(4, 5'(k), 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(4, 5'(k), RES'(k), 1'b1, 1'b0, 1'b0, 1'b1);
      exp_flat[k*RES +: RES] = RES'(k);
    end
    cyc(4, 5'd31, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s5_fill", if4.out_flat, exp_flat);
    check_eq("s5_upd", W'(if4.updated_o), W'(32'hFFFF_FFFF));

    // Hold blocks writes but not select tracking or blanking.
    for (int j = 0; j < 3; j++) begin
      cyc(4, 5'd31, 14'h3FFF, 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("s5_hold_wr", W'(if4.wr_o), W'(0));
    end
    check_eq("s5_hold_flat", if4.out_flat, exp_flat);
    cyc(4, 5'd30, 14'h3FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("s5_hold_settle", W'(if4.settling_o), W'(1));
    check_eq("s5_hold_ch", W'(if4.ch_o), W'(30));
    for (int j = 0; j < 4; j++) cyc(4, 5'd30, 14'h3FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("s5_hold_settle_end", W'(if4.settling_o), W'(0));
    check_eq("s5_hold_flat2", if4.out_flat, exp_flat);

    // Clear beats a simultaneous valid write; select and state survive it.
    cyc(4, 5'd30, 14'h1111, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("s5_clr_flat", if4.out_flat, W'(0));
    check_eq("s5_clr_upd", W'(if4.updated_o), W'(0));
    check_eq("s5_clr_wr", W'(if4.wr_o), W'(0));
    check_eq("s5_clr_ch", W'(if4.ch_o), W'(30));
    cyc(4, 5'd30, 14'h2222, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(4, 5'd30, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s5_post_clr_upd", W'(if4.updated_o), W'(32'h4000_0000));
    flush();

    // Asynchronous reset in the middle of a blanking interval.
    cyc(4, 5'd9, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4, 5'd9, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s6_pre_settle", W'(if4.settling_o), W'(1));
    #2;
    rstn = 1'b0;
    #1;
    check_zero("s6_async");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("s6_ch", W'(if4.ch_o), W'(9));
    check_eq("s6_settle0", W'(if4.settling_o), W'(1));
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      check_eq("s6_settle", W'(if4.settling_o), W'(j < 3));
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
